// File: rtl/hazard_scoreboard.sv
// Per-register result-ready scoreboard that interlocks the IF/ID -> EX boundary.
// Optional `HZD_PERF_EN adds saturating stall_cycles / raw_events counters.
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int REG_W   = 5,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_use,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_use,
  input  logic             id_branch,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [NREGS-1:0] pend_mask
`ifdef HZD_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      raw_events
`endif
);

  logic [LAT_W-1:0] cnt     [NREGS];
  logic [LAT_W-1:0] cnt_nxt [NREGS];
  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] thr;
  logic [LAT_W-1:0] rs_cnt, rt_cnt, rd_cnt;
  logic             raw, waw;

  function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
    if (lat > LAT_W'(MAX_LAT)) return LAT_W'(MAX_LAT);
    return lat;
  endfunction

  // Register 0 is hard-wired, so it never reports a pending result.
  function automatic logic [LAT_W-1:0] cnt_of(input logic [REG_W-1:0] r);
    if (r == '0) return '0;
    return cnt[r];
  endfunction

  always_comb begin
    lat_eff = sat_lat(id_lat);
    thr     = id_branch ? '0 : LAT_W'(1);
    rs_cnt  = cnt_of(id_rs);
    rt_cnt  = cnt_of(id_rt);
    rd_cnt  = cnt_of(id_rd);
    raw     = (id_rs_use && (rs_cnt > thr)) || (id_rt_use && (rt_cnt > thr));
    waw     = id_wr && (id_rd != '0) && (rd_cnt > lat_eff);
    stall   = resetn && id_valid && !flush && !hold && (raw || waw);
    issue   = id_valid && !flush && !hold && !stall;
  end

  // Countdowns keep draining during a stall; a newly issued writer overrides its entry.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (!hold) begin
        if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - LAT_W'(1);
        if (issue && id_wr && (id_rd == REG_W'(r))) cnt_nxt[r] = lat_eff;
      end
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      pend_mask <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r]       <= cnt_nxt[r];
        pend_mask[r] <= (cnt_nxt[r] != '0);
      end
    end
  end

`ifdef HZD_PERF_EN
  logic stall_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q      <= 1'b0;
      stall_cycles <= '0;
      raw_events   <= '0;
    end else if (!hold) begin
      stall_q <= stall;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (stall && raw && !stall_q && (raw_events != '1)) raw_events <= raw_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: latency bubbles, WAW, hold, flush, r0, saturation, reset.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        resetn;
  logic        id_valid, id_rs_use, id_rt_use, id_branch, id_wr, hold, flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_lat;
  logic        stall, issue;
  logic [31:0] pend_mask;
  int          n_checks = 0;
  int          n_errors = 0;
  int          hi_cnt;
`ifdef HZD_PERF_EN
  logic [31:0] stall_cycles, raw_events;
  logic [31:0] sc0, re0;
`endif

  hazard_scoreboard dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rt(id_rt), .id_rt_use(id_rt_use),
    .id_branch(id_branch), .id_rd(id_rd), .id_wr(id_wr), .id_lat(id_lat),
    .hold(hold), .flush(flush), .stall(stall), .issue(issue), .pend_mask(pend_mask)
`ifdef HZD_PERF_EN
    , .stall_cycles(stall_cycles), .raw_events(raw_events)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs, input logic rsu, input int rt,
                       input logic rtu, input logic br, input int rd, input logic wr,
                       input int lat);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rs_use = rsu;
    id_rt     = 5'(rt);
    id_rt_use = rtu;
    id_branch = br;
    id_rd     = 5'(rd);
    id_wr     = wr;
    id_lat    = 4'(lat);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    hold   = 1'b0;
    flush  = 1'b0;
    nop();
    #12;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_pend", pend_mask, 32'h0);
`ifdef HZD_PERF_EN
    check("rst_perf_sc", stall_cycles, 32'h0);
    check("rst_perf_re", raw_events, 32'h0);
`endif
    tick();
    resetn = 1'b1;
    tick();

    // ALU r3 -> ADD reads r3: back to back
    drive(1, 0, 0, 0, 0, 0, 3, 1, 1);
    check("alu_stall", {31'b0, stall}, 32'h0);
    check("alu_issue", {31'b0, issue}, 32'h1);
    tick();
    check("alu_pend3", pend_mask, 32'h8);
    drive(1, 3, 1, 0, 0, 0, 4, 1, 1);
    check("add_stall", {31'b0, stall}, 32'h0);
    check("add_issue", {31'b0, issue}, 32'h1);
    tick();
    check("add_pend", pend_mask, 32'h10);
    nop();
    tick();
    check("alu_drain", pend_mask, 32'h0);

    // LW r5 -> ADD reads r5: one bubble
    drive(1, 0, 0, 0, 0, 0, 5, 1, 2);
    tick();
    check("lw_pend5", pend_mask, 32'h20);
    drive(1, 0, 0, 5, 1, 0, 6, 1, 1);
    check("lw_add_stall1", {31'b0, stall}, 32'h1);
    check("lw_add_issue1", {31'b0, issue}, 32'h0);
    tick();
    check("lw_add_stall2", {31'b0, stall}, 32'h0);
    check("lw_add_issue2", {31'b0, issue}, 32'h1);
    tick();
    nop();
    tick();
    tick();
    check("lw_drain", pend_mask, 32'h0);

    // LW r5 -> BEQ reads r5: two bubbles
`ifdef HZD_PERF_EN
    sc0 = stall_cycles;
    re0 = raw_events;
`endif
    drive(1, 0, 0, 0, 0, 0, 5, 1, 2);
    tick();
    drive(1, 5, 1, 0, 0, 1, 0, 0, 0);
    check("beq_stall1", {31'b0, stall}, 32'h1);
    tick();
    check("beq_stall2", {31'b0, stall}, 32'h1);
    tick();
    check("beq_stall3", {31'b0, stall}, 32'h0);
    check("beq_issue", {31'b0, issue}, 32'h1);
    tick();
`ifdef HZD_PERF_EN
    check("perf_beq_sc", stall_cycles - sc0, 32'd2);
    check("perf_beq_re", raw_events - re0, 32'd1);
`endif
    nop();
    tick();

    // MUL r8 lat 6, bubble, ADDI writes r8 lat 1: WAW stalls while cnt 5,4,3,2
`ifdef HZD_PERF_EN
    sc0 = stall_cycles;
    re0 = raw_events;
`endif
    drive(1, 0, 0, 0, 0, 0, 8, 1, 6);
    tick();
    nop();
    tick();
    drive(1, 0, 0, 0, 0, 0, 8, 1, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("waw_stall_%0d", i), {31'b0, stall}, 32'h1);
      tick();
    end
    check("waw_stall_end", {31'b0, stall}, 32'h0);
    check("waw_issue", {31'b0, issue}, 32'h1);
    tick();
    check("waw_pend8", pend_mask, 32'h100);
    nop();
    tick();
    check("waw_drain", pend_mask, 32'h0);
`ifdef HZD_PERF_EN
    check("perf_waw_sc", stall_cycles - sc0, 32'd4);
    check("perf_waw_re", raw_events - re0, 32'd0);
`endif

    // LW r5 then hold for 3 cycles with dependent ADD waiting
    drive(1, 0, 0, 0, 0, 0, 5, 1, 2);
    tick();
    hold = 1'b1;
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_stall_%0d", i), {31'b0, stall}, 32'h0);
      check($sformatf("hold_issue_%0d", i), {31'b0, issue}, 32'h0);
      check($sformatf("hold_pend_%0d", i), pend_mask, 32'h20);
      tick();
    end
    hold = 1'b0;
    #1;
    check("hold_rel_stall", {31'b0, stall}, 32'h1);
    tick();
    check("hold_rel_stall2", {31'b0, stall}, 32'h0);
    check("hold_rel_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();
    tick();

    // Flush: no stall, no issue, no scoreboard write
    drive(1, 0, 0, 0, 0, 0, 5, 1, 2);
    tick();
    flush = 1'b1;
    drive(1, 5, 1, 0, 0, 0, 10, 1, 3);
    check("flush_stall", {31'b0, stall}, 32'h0);
    check("flush_issue", {31'b0, issue}, 32'h0);
    tick();
    flush = 1'b0;
    check("flush_pend", pend_mask, 32'h20);
    nop();
    tick();

    // Register 0 writer and reader
    drive(1, 0, 0, 0, 0, 0, 0, 1, 4);
    check("r0_wr_issue", {31'b0, issue}, 32'h1);
    tick();
    check("r0_pend", pend_mask, 32'h0);
    drive(1, 0, 1, 0, 1, 1, 0, 0, 0);
    check("r0_rd_stall", {31'b0, stall}, 32'h0);
    check("r0_rd_issue", {31'b0, issue}, 32'h1);
    tick();

    // id_lat=15 saturates to 8: a second lat-15 writer does not WAW-stall, r9 pending 8 cycles
    drive(1, 0, 0, 0, 0, 0, 9, 1, 15);
    tick();
    check("sat_pend9", pend_mask, 32'h200);
    drive(1, 0, 0, 0, 0, 0, 9, 1, 15);
    check("sat_waw_stall", {31'b0, stall}, 32'h0);
    check("sat_waw_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (pend_mask[9]) hi_cnt++;
      tick();
    end
    check("sat_len", 32'(hi_cnt), 32'd8);

    // MUL r7 lat 8, reset mid-count
    drive(1, 0, 0, 0, 0, 0, 7, 1, 8);
    tick();
    nop();
    tick();
    tick();
    check("mul_pend7", pend_mask, 32'h80);
    resetn = 1'b0;
    #1;
    check("rst_mid_pend", pend_mask, 32'h0);
`ifdef HZD_PERF_EN
    check("rst_mid_sc", stall_cycles, 32'h0);
    check("rst_mid_re", raw_events, 32'h0);
`endif
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
    check("rst_mid_stall", {31'b0, stall}, 32'h0);
    tick();
    resetn = 1'b1;
    #1;
    check("post_rst_stall", {31'b0, stall}, 32'h0);
    check("post_rst_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
